// File: rtl/reg_bus_master.sv
// Register-bus initiator: buffers client read/write commands in a small FIFO
// and sequences each one onto the register slave bus, returning read data.
module reg_bus_master #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 2,
  parameter int unsigned       NUM_REGS  = 2,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       READ_LAT  = 1,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(2'b11)
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [7:0]        err_count,
  output logic              busy,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned LAT_W   = 3;
  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_WAIT, ST_RESP} state_t;

  state_t             state_q, state_d;
  logic [ENTRY_W-1:0] fifo_q [DEPTH];
  logic [ENTRY_W-1:0] fifo_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LAT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               push, pop, fifo_empty;
  logic               head_rw, head_in_range;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != CNT_W'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;

  assign {head_rw, head_addr, head_wdata} = fifo_q[rd_ptr_q];
  assign head_in_range = (32'(head_addr) < NUM_REGS);

  // FIFO bookkeeping, bus sequencing and response handling
  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wait_cnt_d  = wait_cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;

    if (push) begin
      fifo_d[wr_ptr_q] = {cmd_rw, cmd_addr, cmd_wdata};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (head_in_range) begin
            rw_d   = head_rw;
            addr_d = head_addr;
            if (head_rw) begin
              state_d = ST_RD;
            end else begin
              wdata_d = head_wdata;
              state_d = ST_WR;
            end
          end else begin
            // Out-of-range commands never reach the bus; reads still answer
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            if (head_rw) begin
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
              rsp_valid_d = 1'b1;
              state_d     = ST_RESP;
            end
          end
        end
      end
      ST_WR: begin
        rw_d    = 1'b1;
        addr_d  = IDLE_ADDR;
        state_d = ST_IDLE;
      end
      ST_RD: begin
        rw_d       = 1'b1;
        addr_d     = IDLE_ADDR;
        wait_cnt_d = LAT_W'(READ_LAT);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - LAT_W'(1);
        if (wait_cnt_q == LAT_W'(1)) begin
          rsp_data_d  = rdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= ST_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_cnt_q  <= '0;
      rw_q        <= 1'b1;
      addr_q      <= IDLE_ADDR;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign rw        = rw_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master: expected bus writes and read responses
// are queued as commands are issued and checked by negedge monitors.
module tb_reg_bus_master;
  localparam logic [1:0] IDLE_A = 2'b11;

  typedef struct packed { logic [1:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] data; logic err; } rsp_t;

  logic clock = 1'b0;
  logic reset_b;
  always #5 clock = ~clock;

  // Main DUT (READ_LAT = 1)
  logic        cmd_valid, cmd_ready, cmd_rw, rsp_valid, rsp_ready, rsp_err, busy, rw;
  logic [1:0]  cmd_addr, addr;
  logic [31:0] cmd_wdata, rsp_data, wdata, rdata;
  logic [7:0]  err_count;

  reg_bus_master u_dut (
    .clock(clock), .reset_b(reset_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .err_count(err_count), .busy(busy),
    .rw(rw), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  // Second DUT built with READ_LAT = 3
  logic        d3_cmd_valid, d3_cmd_ready, d3_cmd_rw, d3_rsp_valid, d3_rsp_ready;
  logic        d3_rsp_err, d3_busy, d3_rw;
  logic [1:0]  d3_cmd_addr, d3_addr;
  logic [31:0] d3_cmd_wdata, d3_rsp_data, d3_wdata, d3_rdata;
  logic [7:0]  d3_err_count;

  reg_bus_master #(.READ_LAT(3)) u_dut3 (
    .clock(clock), .reset_b(reset_b),
    .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_rw(d3_cmd_rw),
    .cmd_addr(d3_cmd_addr), .cmd_wdata(d3_cmd_wdata),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_data(d3_rsp_data),
    .rsp_err(d3_rsp_err), .err_count(d3_err_count), .busy(d3_busy),
    .rw(d3_rw), .addr(d3_addr), .wdata(d3_wdata), .rdata(d3_rdata)
  );

  // Register-file slaves: write when rw=0, registered read path of READ_LAT stages
  logic [31:0] s1_regs [2];
  logic [31:0] s3_regs [2];
  logic [31:0] s3_pipe [3];

  always @(posedge clock) begin
    if (!rw && addr < 2'd2) s1_regs[addr[0]] <= wdata;
    rdata <= (addr < 2'd2) ? s1_regs[addr[0]] : 32'h0;
    if (!d3_rw && d3_addr < 2'd2) s3_regs[d3_addr[0]] <= d3_wdata;
    s3_pipe[0] <= (d3_addr < 2'd2) ? s3_regs[d3_addr[0]] : 32'h0;
    s3_pipe[1] <= s3_pipe[0];
    s3_pipe[2] <= s3_pipe[1];
  end
  assign d3_rdata = s3_pipe[2];

  int checks = 0;
  int errors = 0;
  wr_t  exp_wr[$];
  rsp_t exp_rsp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: bus writes, response handshakes, response stability
  logic        prev_rw = 1'b1, prev_rv = 1'b0, prev_hs = 1'b0, prev_re = 1'b0;
  logic [31:0] prev_rd = '0;

  always @(negedge clock) begin
    if (reset_b) begin
      if (!rw) begin
        chk("rw_low_one_cycle", 32'(prev_rw), 32'd1);
        if (exp_wr.size() == 0) begin
          chk("unexpected_bus_write", 32'(exp_wr.size()), 32'd1);
        end else begin
          chk("wr_addr", 32'(addr), 32'(exp_wr[0].addr));
          chk("wr_data", wdata, exp_wr[0].data);
          exp_wr.delete(0);
        end
      end
      if (prev_rv && !prev_hs) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_hold_data", rsp_data, prev_rd);
        chk("rsp_hold_err", 32'(rsp_err), 32'(prev_re));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", 32'(exp_rsp.size()), 32'd1);
        end else begin
          chk("rsp_data", rsp_data, exp_rsp[0].data);
          chk("rsp_err", 32'(rsp_err), 32'(exp_rsp[0].err));
          exp_rsp.delete(0);
        end
      end
    end
    prev_rw <= rw;
    prev_rv <= rsp_valid;
    prev_hs <= rsp_valid && rsp_ready;
    prev_rd <= rsp_data;
    prev_re <= rsp_err;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one command; returns just after the edge that accepted it
  task automatic send(input logic r, input logic [1:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_rw = r; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rsp_valid) && n < 500) begin tick(); n++; end
    if (n >= 500) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    reset_b = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b1; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    d3_cmd_valid = 1'b0; d3_cmd_rw = 1'b1; d3_cmd_addr = '0; d3_cmd_wdata = '0;
    d3_rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin s1_regs[i] = '0; s3_regs[i] = '0; end
    for (int i = 0; i < 3; i++) s3_pipe[i] = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rw", 32'(rw), 32'd1);
    chk("rst_addr", 32'(addr), 32'(IDLE_A));
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset_b = 1'b1;
    tick();

    // Write then read back addr 0, with latencies
    exp_wr.push_back('{addr: 2'd0, data: 32'hDEADBEEF});
    send(1'b0, 2'd0, 32'hDEADBEEF);
    n = 1;
    while (rw && n < 50) begin tick(); n++; end
    chk("write_latency", 32'(n), 32'd2);
    wait_idle();
    exp_rsp.push_back('{data: 32'hDEADBEEF, err: 1'b0});
    send(1'b1, 2'd0, 32'h0);
    n = 1;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk("read_latency", 32'(n), 32'd4);
    wait_idle();

    // Burst of six alternating writes, then read both registers back
    for (int i = 1; i <= 6; i++) begin
      exp_wr.push_back('{addr: 2'((i - 1) % 2), data: 32'(i)});
      send(1'b0, 2'((i - 1) % 2), 32'(i));
    end
    wait_idle();
    exp_rsp.push_back('{data: 32'd5, err: 1'b0});
    send(1'b1, 2'd0, 32'h0);
    exp_rsp.push_back('{data: 32'd6, err: 1'b0});
    send(1'b1, 2'd1, 32'h0);
    wait_idle();

    // Back-pressured read: queue fills, bus stays idle until the handshake
    rsp_ready = 1'b0;
    exp_rsp.push_back('{data: 32'd6, err: 1'b0});
    send(1'b1, 2'd1, 32'h0);
    exp_wr.push_back('{addr: 2'd0, data: 32'hA1}); send(1'b0, 2'd0, 32'hA1);
    exp_wr.push_back('{addr: 2'd1, data: 32'hB2}); send(1'b0, 2'd1, 32'hB2);
    exp_wr.push_back('{addr: 2'd0, data: 32'hC3}); send(1'b0, 2'd0, 32'hC3);
    exp_wr.push_back('{addr: 2'd1, data: 32'hD4}); send(1'b0, 2'd1, 32'hD4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    chk("held_rsp_valid", 32'(rsp_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rw !== 1'b1 || addr !== IDLE_A || rsp_valid !== 1'b1) bad++;
    end
    chk("no_bus_activity_while_held", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    wait_idle();

    // Out-of-range read and write, then saturate err_count
    exp_rsp.push_back('{data: 32'h0, err: 1'b1});
    send(1'b1, 2'd3, 32'h0);
    send(1'b0, 2'd2, 32'h55);
    wait_idle();
    chk("err_count_2", 32'(err_count), 32'd2);
    for (int i = 0; i < 252; i++) send(1'b0, 2'(2 + (i % 2)), 32'(i));
    wait_idle();
    chk("err_count_254", 32'(err_count), 32'd254);
    for (int i = 0; i < 48; i++) send(1'b0, 2'd2, 32'(i));
    wait_idle();
    chk("err_count_sat", 32'(err_count), 32'd255);

    // Reset during WAIT abandons the read
    send(1'b1, 2'd0, 32'h0);
    tick();
    tick();
    reset_b = 1'b0;
    tick();
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rw", 32'(rw), 32'd1);
    chk("mid_rst_addr", 32'(addr), 32'(IDLE_A));
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    reset_b = 1'b1;
    tick();
    exp_rsp.push_back('{data: 32'hC3, err: 1'b0});
    send(1'b1, 2'd0, 32'h0);
    wait_idle();

    // READ_LAT = 3 instance: WAIT spans three cycles
    d3_cmd_valid = 1'b1; d3_cmd_rw = 1'b0; d3_cmd_addr = 2'd1; d3_cmd_wdata = 32'h12345678;
    tick();
    d3_cmd_valid = 1'b0;
    n = 0;
    while (d3_busy && n < 50) begin tick(); n++; end
    chk("lat3_write_done", 32'(d3_busy), 32'd0);
    d3_cmd_valid = 1'b1; d3_cmd_rw = 1'b1; d3_cmd_addr = 2'd1;
    tick();
    d3_cmd_valid = 1'b0;
    n = 1;
    while (!d3_rsp_valid && n < 50) begin tick(); n++; end
    chk("lat3_read_latency", 32'(n), 32'd6);
    chk("lat3_rsp_data", d3_rsp_data, 32'h12345678);
    chk("lat3_rsp_err", 32'(d3_rsp_err), 32'd0);
    d3_rsp_ready = 1'b1;
    tick();
    chk("lat3_rsp_cleared", 32'(d3_rsp_valid), 32'd0);
    d3_rsp_ready = 1'b0;

    repeat (2) tick();
    chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
